// File: rtl/traffic_light_multi.sv
// Round-robin traffic light controller for N_DIR approaches with pass requests,
// green extension/cut-short, and a night-mode yellow flash.
module traffic_light_multi #(
   parameter int N_DIR    = 2,
   parameter int CNT_W    = 12,
   parameter int T_G      = 1024,
   parameter int T_Y      = 512,
   parameter int T_ALLRED = 128,
   parameter int T_MIN_G  = 128,
   parameter int T_FLASH  = 64
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [N_DIR-1:0]           pass,
   input  logic                       night,
   output logic [N_DIR-1:0]           R,
   output logic [N_DIR-1:0]           G,
   output logic [N_DIR-1:0]           Y,
   output logic [$clog2(N_DIR)-1:0]   cur_dir
);

   localparam int DW = $clog2(N_DIR);

   localparam logic [CNT_W-1:0] G_END     = CNT_W'(T_G - 1);
   localparam logic [CNT_W-1:0] Y_END     = CNT_W'(T_Y - 1);
   localparam logic [CNT_W-1:0] AR_END    = CNT_W'(T_ALLRED - 1);
   localparam logic [CNT_W-1:0] MIN_G_END = CNT_W'(T_MIN_G - 1);
   localparam logic [CNT_W-1:0] FL_END    = CNT_W'(T_FLASH - 1);

   typedef enum logic [1:0] {GREEN, YELLOW, ALL_RED, FLASH} phase_t;

   phase_t            phase, phase_nx;
   logic [DW-1:0]     dir_nx;
   logic [CNT_W-1:0]  timer, timer_nx;
   logic [N_DIR-1:0]  pend, pend_nx;
   logic              flash, flash_nx;
   // Set while the ALL_RED that follows FLASH is running; forces a restart at direction 0.
   logic              restart, restart_nx;

   logic [N_DIR-1:0]  dir_mask;
   logic              other_req;
   logic [DW-1:0]     rr_dir;
   logic [DW-1:0]     cand;
   logic              found;

   assign dir_mask  = N_DIR'(1) << cur_dir;
   assign other_req = |((pend | pass) & ~dir_mask);

   // Next owner: first pending direction after cur_dir, else simply the next one.
   // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      rr_dir = DW'((int'(cur_dir) + 1) % N_DIR);
      cand   = '0;
      found  = 1'b0;
      for (int k = 1; k <= N_DIR; k++) begin
         cand = DW'((int'(cur_dir) + k) % N_DIR);
         if (!found && pend[cand]) begin
            rr_dir = cand;
            found  = 1'b1;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments; combinational blocks use blocking ones.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         phase   <= GREEN;
         cur_dir <= '0;
         timer   <= '0;
         pend    <= '0;
         flash   <= 1'b0;
         restart <= 1'b0;
      end else begin
         phase   <= phase_nx;
         cur_dir <= dir_nx;
         timer   <= timer_nx;
         pend    <= pend_nx;
         flash   <= flash_nx;
         restart <= restart_nx;
      end
   end

   always_comb begin
      phase_nx   = phase;
      dir_nx     = cur_dir;
      timer_nx   = timer + CNT_W'(1);
      flash_nx   = flash;
      restart_nx = restart;
      pend_nx    = pend | (pass & ~((phase == GREEN) ? dir_mask : '0));
      unique case (phase)
         GREEN: begin
            if (other_req && timer >= MIN_G_END) begin
               phase_nx = YELLOW;
               timer_nx = '0;
            end else if (pass[cur_dir]) begin
               timer_nx = '0;
            end else if (timer == G_END) begin
               phase_nx = YELLOW;
               timer_nx = '0;
            end
         end
         YELLOW: begin
            if (timer == Y_END) begin
               phase_nx = ALL_RED;
               timer_nx = '0;
            end
         end
         ALL_RED: begin
            if (timer == AR_END) begin
               timer_nx = '0;
               if (night) begin
                  phase_nx = FLASH;
                  flash_nx = 1'b1;
               end else if (restart) begin
                  phase_nx   = GREEN;
                  dir_nx     = '0;
                  pend_nx    = '0;
                  restart_nx = 1'b0;
               end else begin
                  phase_nx        = GREEN;
                  dir_nx          = rr_dir;
                  pend_nx[rr_dir] = 1'b0;
               end
            end
         end
         FLASH: begin
            if (!night) begin
               phase_nx   = ALL_RED;
               timer_nx   = '0;
               restart_nx = 1'b1;
            end else if (timer == FL_END) begin
               timer_nx = '0;
               flash_nx = ~flash;
            end
         end
         default: phase_nx = GREEN;
      endcase
   end

   always_comb begin
      R = '1;
      G = '0;
      Y = '0;
      unique case (phase)
         GREEN: begin
            R = ~dir_mask;
            G = dir_mask;
         end
         YELLOW: begin
            R = ~dir_mask;
            Y = dir_mask;
         end
         ALL_RED: R = '1;
         FLASH: begin
            R = '0;
            Y = {N_DIR{flash}};
         end
         default: R = '1;
      endcase
   end

endmodule

// File: tb/tb_traffic_light_multi.sv
// Directed bench for traffic_light_multi (defaults, N_DIR=2): expected lamp states
// are queued with their cycle number and compared when the run reaches that cycle.
module tb_traffic_light_multi;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [1:0] pass = 2'b00;
   logic       night = 1'b0;
   logic [1:0] R, G, Y;
   logic       cur_dir;

   traffic_light_multi dut (
      .clk     (clk),
      .rst     (rst),
      .pass    (pass),
      .night   (night),
      .R       (R),
      .G       (G),
      .Y       (Y),
      .cur_dir (cur_dir)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         cyc;
      string      tag;
      logic [6:0] val;
      logic [6:0] mask;
   } exp_t;

   exp_t exp_q[$];
   int   cyc;
   int   total = 0;
   int   bad   = 0;

   localparam logic [6:0] ALL  = 7'b1111111;
   localparam logic [6:0] NDIR = 7'b1111110;

   task automatic check(input string tag, input logic [6:0] obs, input logic [6:0] exp,
                        input logic [6:0] mask);
      total++;
      assert ((obs & mask) === (exp & mask)) else begin
         bad++;
         $error("FAIL %s: observed RGYd=%b expected RGYd=%b", tag, obs & mask, exp & mask);
      end
   endtask

   task automatic push(input int c, input string tag, input logic [1:0] r, input logic [1:0] g,
                       input logic [1:0] y, input logic d, input logic [6:0] mask);
      exp_t e;
      e.cyc  = c;
      e.tag  = $sformatf("%s@%0d", tag, c);
      e.val  = {r, g, y, d};
      e.mask = mask;
      exp_q.push_back(e);
   endtask

   task automatic green(input int c, input string tag, input logic d);
      logic [1:0] m;
      m = 2'b01 << d;
      push(c, tag, ~m, m, 2'b00, d, ALL);
   endtask

   task automatic yellow(input int c, input string tag, input logic d);
      logic [1:0] m;
      m = 2'b01 << d;
      push(c, tag, ~m, 2'b00, m, d, ALL);
   endtask

   task automatic allred(input int c, input string tag, input logic d, input bit dcare);
      push(c, tag, 2'b11, 2'b00, 2'b00, d, dcare ? ALL : NDIR);
   endtask

   task automatic flashing(input int c, input string tag, input logic on);
      push(c, tag, 2'b00, 2'b00, {on, on}, 1'b0, NDIR);
   endtask

   task automatic drain();
      exp_t e;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
         e = exp_q.pop_front();
         check(e.tag, {R, G, Y, cur_dir}, e.val, e.mask);
      end
   endtask

   task automatic run_to(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
         cyc++;
         drain();
      end
   endtask

   task automatic finish_scn();
      if (exp_q.size() > 0) run_to(exp_q[$].cyc);
   endtask

   // Assert reset one tick past an edge, check the asynchronous reset decode, release it.
   task automatic do_reset(input string tag);
      rst = 1'b0;
      #1;
      check({tag, "_async_rst"}, {R, G, Y, cur_dir}, {2'b10, 2'b01, 2'b00, 1'b0}, ALL);
      @(posedge clk);
      #1;
      rst = 1'b1;
      cyc = 0;
      drain();
   endtask

   initial begin
      @(posedge clk);
      #1;

      // No requests: full two-direction rotation.
      green(0, "s1", 0);       green(1023, "s1", 0);
      yellow(1024, "s1", 0);   yellow(1535, "s1", 0);
      allred(1536, "s1", 0, 1); allred(1663, "s1", 0, 1);
      green(1664, "s1", 1);    green(2687, "s1", 1);
      yellow(2688, "s1", 1);   allred(3327, "s1", 1, 1);
      green(3328, "s1", 0);
      do_reset("s1");
      finish_scn();

      // Competing request after minimum green; pend[1] must clear when direction 1 takes green.
      green(0, "s2", 0);       green(200, "s2", 0);
      yellow(201, "s2", 0);    yellow(712, "s2", 0);
      allred(713, "s2", 0, 1); allred(840, "s2", 0, 1);
      green(841, "s2", 1);     green(1864, "s2", 1);
      yellow(1865, "s2", 1);   green(2505, "s2", 0);
      green(2700, "s2", 0);
      do_reset("s2");
      run_to(200); pass = 2'b10; run_to(201); pass = 2'b00;
      finish_scn();

      // Early competing request: green held until minimum green.
      green(127, "s3", 0);     yellow(128, "s3", 0);
      allred(640, "s3", 0, 1); allred(767, "s3", 0, 1);
      green(768, "s3", 1);
      do_reset("s3");
      run_to(50); pass = 2'b10; run_to(51); pass = 2'b00;
      finish_scn();

      // Own-direction extension restarts the green timer.
      green(1024, "s4", 0);    green(1524, "s4", 0);
      yellow(1525, "s4", 0);
      do_reset("s4");
      run_to(500); pass = 2'b01; run_to(501); pass = 2'b00;
      finish_scn();

      // Simultaneous own and other request: other wins.
      green(500, "s5", 0);     yellow(501, "s5", 0);
      do_reset("s5");
      run_to(500); pass = 2'b11; run_to(501); pass = 2'b00;
      finish_scn();

      // Night mode: flash, exit through ALL_RED to direction 0 with pend cleared.
      night = 1'b1;
      allred(1663, "s6", 0, 1);
      flashing(1664, "s6", 1); flashing(1727, "s6", 1);
      flashing(1728, "s6", 0); flashing(1791, "s6", 0);
      flashing(1792, "s6", 1); flashing(2000, "s6", 0);
      allred(2001, "s6", 0, 0); allred(2128, "s6", 0, 0);
      green(2129, "s6", 0);    green(2257, "s6", 0);
      do_reset("s6");
      run_to(1900); pass = 2'b10; run_to(1901); pass = 2'b00;
      run_to(2000); night = 1'b0;
      finish_scn();

      // Reset in the middle of YELLOW, then the sequence restarts from cycle 0.
      yellow(1300, "s7", 0);
      do_reset("s7_pre");
      finish_scn();
      green(0, "s7", 0);       green(1023, "s7", 0);
      yellow(1024, "s7", 0);
      do_reset("s7");
      finish_scn();

      while (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         total++;
         bad++;
         $display("FAIL %s: expectation never reached, observed=none expected=%b", e.tag, e.val);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
